// File: rtl/fec_pkg.sv
// fec_pkg: shared types and helpers for the downlink frame sequencer
package fec_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP} dl_seq_state_t;
  localparam int DL_SEQ_MAX_MODES = 16;
  function automatic int dl_frame_bits(input int width_m1, input int depth_m1);
    return (width_m1 + 1) * (depth_m1 + 1);
  endfunction
endpackage

// File: rtl/dl_baud_tick.sv
// dl_baud_tick: bit-period divider, ticks every div+1 cycles, restarts on clr
module dl_baud_tick #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt;
  assign tick = cnt == div;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/dl_frame_sequencer.sv
// dl_frame_sequencer: preamble/payload/gap serializer with repeats, abort and start rejection
module dl_frame_sequencer
  import fec_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 8,
  parameter int NUM_MODES  = 4,
  parameter int DIV_WIDTH  = 8,
  parameter int PRE_WIDTH  = 6,
  parameter int GAP_WIDTH  = 8,
  parameter int REP_WIDTH  = 4,
  parameter logic [NUM_MODES-1:0] ERR_CLR_MASK = {{(NUM_MODES-1){1'b0}}, 1'b1},
  localparam int MODE_W = $clog2(NUM_MODES),
  localparam int WW = $clog2(DATA_WIDTH),
  localparam int DW = $clog2(DATA_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [MODE_W-1:0]                mode,
  input  logic [NUM_MODES*WW-1:0]          width_tbl,
  input  logic [NUM_MODES*DW-1:0]          depth_tbl,
  input  logic [DATA_DEPTH*DATA_WIDTH-1:0] par_in,
  input  logic [DIV_WIDTH-1:0]             clk_div,
  input  logic [PRE_WIDTH-1:0]             pre_len,
  input  logic [GAP_WIDTH-1:0]             gap_len,
  input  logic [REP_WIDTH-1:0]             rep_cnt,
  input  logic                             err_inj_enable,
  output logic                             err_inj_clear,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted,
  output logic                             cfg_err,
  output logic [REP_WIDTH-1:0]             frame_idx,
  output logic                             dl_out,
  output logic                             dl_en
);
  dl_seq_state_t state, state_n;
  logic [WW-1:0] width_l, wsel, c, c_n;
  logic [DW-1:0] depth_l, r, r_n;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_l, psrc;
  logic [PRE_WIDTH-1:0] pre_l, psel, p, p_n;
  logic [GAP_WIDTH-1:0] gap_l, g, g_n;
  logic [REP_WIDTH-1:0] rep_l, f_n;
  logic [DIV_WIDTH-1:0] div_l;
  logic clr_l, mode_ok, accept, fr, tick;
  logic done_n, ab_n, cerr_n, iclr_n, en_n, out_n;

  assign busy = state != S_IDLE;

  dl_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == S_IDLE),
    .div  (div_l),
    .tick (tick)
  );

  // On the accepting edge the latches are not loaded yet, so the first bit comes from the inputs
  always_comb begin
    mode_ok = 32'(mode) < NUM_MODES;
    accept  = state == S_IDLE && start && !abort && mode_ok;
    wsel    = accept ? width_tbl[mode*WW +: WW] : width_l;
    psel    = accept ? pre_len : pre_l;
    psrc    = (state == S_IDLE) ? par_in : par_l;
    state_n = state;
    p_n     = p;
    g_n     = g;
    r_n     = r;
    c_n     = c;
    f_n     = frame_idx;
    fr      = 1'b0;
    done_n  = 1'b0;
    ab_n    = 1'b0;
    cerr_n  = 1'b0;
    iclr_n  = 1'b0;
    case (state)
      S_IDLE: begin
        cerr_n = start && !abort && !mode_ok;
        if (accept) begin
          f_n = '0;
          fr  = 1'b1;
        end
      end
      S_PREAMBLE: if (tick) begin
        if (p == pre_l - PRE_WIDTH'(1)) begin
          state_n = S_PAYLOAD;
          r_n     = '0;
          c_n     = width_l;
        end else p_n = p + 1'b1;
      end
      S_PAYLOAD: if (tick) begin
        if (c != '0) c_n = c - 1'b1;
        else if (r != depth_l) begin
          r_n = r + 1'b1;
          c_n = width_l;
        end else if (frame_idx < rep_l) begin
          f_n = frame_idx + 1'b1;
          if (gap_l != '0) begin
            state_n = S_GAP;
            g_n     = '0;
          end else fr = 1'b1;
        end else begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          iclr_n  = clr_l;
        end
      end
      S_GAP: if (tick) begin
        if (g == gap_l - GAP_WIDTH'(1)) fr = 1'b1;
        else g_n = g + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    if (fr) begin
      state_n = (psel != '0) ? S_PREAMBLE : S_PAYLOAD;
      p_n     = '0;
      r_n     = '0;
      c_n     = wsel;
    end
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      f_n     = '0;
      ab_n    = 1'b1;
      done_n  = 1'b0;
      iclr_n  = 1'b0;
    end
    en_n  = state_n == S_PREAMBLE || state_n == S_PAYLOAD;
    out_n = (state_n == S_PREAMBLE) ? ~p_n[0] : (state_n == S_PAYLOAD) ? psrc[r_n][c_n] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= S_IDLE;
      p             <= '0;
      g             <= '0;
      r             <= '0;
      c             <= '0;
      frame_idx     <= '0;
      dl_en         <= 1'b0;
      dl_out        <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      cfg_err       <= 1'b0;
      err_inj_clear <= 1'b0;
      width_l       <= '0;
      depth_l       <= '0;
      par_l         <= '0;
      pre_l         <= '0;
      gap_l         <= '0;
      rep_l         <= '0;
      div_l         <= '0;
      clr_l         <= 1'b0;
    end else begin
      state         <= state_n;
      p             <= p_n;
      g             <= g_n;
      r             <= r_n;
      c             <= c_n;
      frame_idx     <= f_n;
      dl_en         <= en_n;
      dl_out        <= out_n;
      done          <= done_n;
      aborted       <= ab_n;
      cfg_err       <= cerr_n;
      err_inj_clear <= iclr_n;
      if (accept) begin
        width_l <= width_tbl[mode*WW +: WW];
        depth_l <= depth_tbl[mode*DW +: DW];
        par_l   <= par_in;
        pre_l   <= pre_len;
        gap_l   <= gap_len;
        rep_l   <= rep_cnt;
        div_l   <= clk_div;
        clr_l   <= err_inj_enable & ERR_CLR_MASK[mode];
      end
    end
endmodule

// File: tb/tb_dl_frame_sequencer.sv
// tb_dl_frame_sequencer: randomized frames checked cycle by cycle against a bit-list model
module tb_dl_frame_sequencer;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, err_inj_enable = 0;
  logic [1:0] mode = 0;
  logic [8:0] width_tbl = 0, depth_tbl = 0;
  logic [63:0] par_in = 0;
  logic [7:0] clk_div = 0, gap_len = 0;
  logic [5:0] pre_len = 0;
  logic [3:0] rep_cnt = 0, frame_idx;
  logic err_inj_clear, busy, done, aborted, cfg_err, dl_out, dl_en;
  int checks = 0, errors = 0;
  localparam logic [2:0] MASK = 3'b101;

  typedef struct packed {logic en; logic out; logic [3:0] fi;} ent_t;

  dl_frame_sequencer #(.NUM_MODES(3), .ERR_CLR_MASK(MASK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .width_tbl(width_tbl), .depth_tbl(depth_tbl), .par_in(par_in), .clk_div(clk_div),
    .pre_len(pre_len), .gap_len(gap_len), .rep_cnt(rep_cnt), .err_inj_enable(err_inj_enable),
    .err_inj_clear(err_inj_clear), .busy(busy), .done(done), .aborted(aborted),
    .cfg_err(cfg_err), .frame_idx(frame_idx), .dl_out(dl_out), .dl_en(dl_en)
  );

  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] vec();
    return {21'b0, busy, dl_en, dl_out, done, aborted, cfg_err, err_inj_clear, frame_idx};
  endfunction

  task automatic scramble();
    start = 1'($urandom);
    mode = 2'($urandom);
    width_tbl = 9'($urandom);
    depth_tbl = 9'($urandom);
    par_in = {$urandom, $urandom};
    pre_len = 6'($urandom);
    gap_len = 8'($urandom);
    rep_cnt = 4'($urandom);
    err_inj_enable = 1'($urandom);
  endtask

  task automatic run_frame(input logic [1:0] md, input logic [7:0] cdiv, input logic [5:0] pl,
                           input logic [7:0] gl, input logic [3:0] rc, input logic een,
                           input logic [8:0] tw, input logic [8:0] td, input logic [63:0] par,
                           input int abort_at);
    ent_t q[$];
    int w, d, per;
    ent_t e;
    logic iclr;
    w = int'(tw[md*3 +: 3]);
    d = int'(td[md*3 +: 3]);
    per = int'(cdiv) + 1;
    iclr = een & MASK[md];
    for (int f = 0; f <= int'(rc); f++) begin
      if (f > 0) repeat (int'(gl) * per) q.push_back('{en: 1'b0, out: 1'b0, fi: 4'(f)});
      for (int i = 0; i < int'(pl); i++) repeat (per) q.push_back('{en: 1'b1, out: (i % 2 == 0), fi: 4'(f)});
      for (int rr = 0; rr <= d; rr++)
        for (int cc = w; cc >= 0; cc--) repeat (per) q.push_back('{en: 1'b1, out: par[rr*8+cc], fi: 4'(f)});
    end
    mode = md; clk_div = cdiv; pre_len = pl; gap_len = gl; rep_cnt = rc; err_inj_enable = een;
    width_tbl = tw; depth_tbl = td; par_in = par; start = 1; abort = 0;
    @(negedge clk);
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      chk("cyc", vec(), {21'b0, 1'b1, e.en, e.out, 4'b0, e.fi});
      scramble();
      if (i == abort_at) begin
        abort = 1; start = 0;
        @(negedge clk);
        abort = 0;
        chk("abort", vec(), 32'h40);
        return;
      end
      @(negedge clk);
    end
    start = 0;
    chk("end", vec() & 32'h7F0, iclr ? 32'h90 : 32'h80);
    @(negedge clk);
    chk("post", vec() & 32'h7F0, 32'h0);
  endtask

  initial begin
    #12;
    @(negedge clk);
    chk("reset", vec(), 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle", vec(), 0);
    run_frame(2'd0, 8'd0, 6'd4, 8'd0, 4'd0, 1'b1, 9'o007, 9'o001, 64'h3CA5, -1);
    run_frame(2'd1, 8'd3, 6'd0, 8'd0, 4'd0, 1'b1, 9'o030, 9'o000, 64'hF9, -1);
    run_frame(2'd2, 8'd1, 6'd2, 8'd2, 4'd2, 1'b1, 9'o300, 9'o000, 64'hA, -1);
    run_frame(2'd0, 8'd0, 6'd0, 8'd0, 4'd0, 1'b1, 9'o007, 9'o001, 64'h3CA5, 5);
    run_frame(2'd0, 8'd0, 6'd1, 8'd0, 4'd0, 1'b1, 9'o007, 9'o001, 64'h1234, -1);
    mode = 2'd3; start = 1;
    @(negedge clk);
    start = 0;
    chk("cfgerr", vec(), 32'h20);
    @(negedge clk);
    chk("cfgerr_end", vec(), 0);
    mode = 2'd0; start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start_abort", vec(), 0);
    @(negedge clk);
    chk("start_abort2", vec(), 0);
    mode = 2'd0; clk_div = 3; pre_len = 6; width_tbl = 9'o007; depth_tbl = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("async_rst", vec(), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_idle", vec(), 0);
    run_frame(2'd1, 8'd2, 6'd3, 8'd1, 4'd1, 1'b1, 9'o050, 9'o020, 64'hC3C3, -1);
    for (int n = 0; n < 30; n++)
      run_frame(2'($urandom_range(0, 2)), 8'($urandom_range(0, 3)), 6'($urandom_range(0, 5)),
                8'($urandom_range(0, 3)), 4'($urandom_range(0, 2)), 1'($urandom),
                9'($urandom), 9'($urandom), {$urandom, $urandom},
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
